cpri_txdata_pack: RTL

- Transmit-side counterpart of the CPRI uplink unpacker.
- Takes per-RE, per-antenna 16-bit I/Q samples and applies per-PRB, per-antenna block-floating-point compression to 7+7 bits.
- Packs 4 antennas × 14 bits into 64-bit CPRI words and emits 96-word chunks: header, AGC, payload, reserved.
- Sits between the beamforming/IQ source and the CPRI TX framer.

---
 rtl/cpri_txdata_pack.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/cpri_txdata_pack.sv
// CPRI TX packer: per-PRB/antenna block-floating-point compression to 7+7 bits, 96-word chunk output.
// Optional rounding before the shift when CPRI_TX_ROUND_EN is defined.
module cpri_txdata_pack #(
  parameter int ANT         = 4,
  parameter int PRB_PER_SYM = 132,
  parameter int CHUNK_WORDS = 96
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [ANT*32-1:0]    i_iq_data,
  input  logic                 i_iq_vld,
  input  logic                 i_iq_last,
  output logic                 o_iq_ready,
  output logic [63:0]          o_cpri_tx_data,
  output logic [6:0]           o_cpri_tx_addr,
  output logic                 o_cpri_tx_vld,
  input  logic                 i_cpri_tx_ready,
  output logic                 o_cpri_tx_last,
  output logic                 o_sym_done
);

  localparam int         SYM_RES   = PRB_PER_SYM * 12;
  localparam logic [6:0] LAST_ADDR = 7'(CHUNK_WORDS - 1);
  localparam logic [6:0] LAST_RE   = 7'd95;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_RSV} state_t;

  function automatic logic [14:0] mag(input logic [15:0] v);
    return v[15] ? ~v[14:0] : v[14:0];
  endfunction

  function automatic logic [3:0] shift_of(input logic [14:0] m);
    logic [3:0] s;
    s = 4'd9;
    for (int k = 8; k >= 0; k--)
      if ((m >> k) <= 15'd63) s = 4'(k);
    return s;
  endfunction

  function automatic logic [6:0] compress(input logic [15:0] v, input logic [3:0] sh);
`ifdef CPRI_TX_ROUND_EN
    logic signed [16:0] bias, t, r;
    bias = (sh == 4'd0) ? 17'sd0 : (17'sd1 <<< (sh - 4'd1));
    t    = $signed({v[15], v}) + bias;
    r    = t >>> sh;
    if (r > 17'sd63)       return 7'h3F;
    else if (r < -17'sd64) return 7'h40;
    else                   return r[6:0];
`else
    logic signed [15:0] r;
    r = $signed(v) >>> sh;
    return r[6:0];
`endif
  endfunction

  // Input side: ping-pong banks of raw samples, compression happens on readout
  logic [127:0] mem [2][96];
  logic [127:0] agc [2];
  logic [6:0]   nre [2];
  logic [7:0]   bchunk [2];
  logic [3:0]   bsym [2];
  logic [1:0]   bend;
  logic [1:0]   full;
  logic         wbank, rbank;
  logic [6:0]   wr_re;
  logic [3:0]   re_in_prb;
  logic [2:0]   prb_in_chunk;
  logic [10:0]  re_in_sym;
  logic [7:0]   chunk_idx;
  logic [3:0]   sym_idx;
  logic [14:0]  m_run [4];
  logic [14:0]  m_new [4];
  logic         accept, sym_end, close_bank, free_bank;

  assign o_iq_ready = !full[wbank];
  assign accept     = i_iq_vld && o_iq_ready;
  assign sym_end    = i_iq_last || (re_in_sym == 11'(SYM_RES - 1));
  assign close_bank = accept && ((wr_re == LAST_RE) || sym_end);

  always_comb begin
    for (int a = 0; a < 4; a++) begin
      m_new[a] = (re_in_prb == 4'd0) ? 15'd0 : m_run[a];
      if (mag(i_iq_data[a*32+16 +: 16]) > m_new[a]) m_new[a] = mag(i_iq_data[a*32+16 +: 16]);
      if (mag(i_iq_data[a*32 +: 16]) > m_new[a])    m_new[a] = mag(i_iq_data[a*32 +: 16]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) mem[wbank][wr_re] <= i_iq_data;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      full <= '0; bend <= '0; wbank <= 1'b0;
      wr_re <= '0; re_in_prb <= '0; prb_in_chunk <= '0; re_in_sym <= '0;
      chunk_idx <= '0; sym_idx <= '0;
      for (int b = 0; b < 2; b++) begin
        agc[b] <= '0; nre[b] <= '0; bchunk[b] <= '0; bsym[b] <= '0;
      end
      for (int a = 0; a < 4; a++) m_run[a] <= '0;
    end else begin
      if (free_bank) begin
        full[rbank] <= 1'b0;
        agc[rbank]  <= '0;
      end
      if (accept) begin
        // Shift is rewritten on every RE so it is final at the PRB's last accepted RE
        for (int a = 0; a < 4; a++) begin
          m_run[a] <= m_new[a];
          agc[wbank][a*32 + 4*prb_in_chunk +: 4] <= shift_of(m_new[a]);
        end
        re_in_sym <= sym_end ? 11'd0 : re_in_sym + 11'd1;
        if (close_bank) begin
          full[wbank]   <= 1'b1;
          nre[wbank]    <= wr_re + 7'd1;
          bchunk[wbank] <= chunk_idx;
          bsym[wbank]   <= sym_idx;
          bend[wbank]   <= sym_end;
          wbank         <= ~wbank;
          wr_re         <= '0;
          re_in_prb     <= '0;
          prb_in_chunk  <= '0;
          if (sym_end) begin
            chunk_idx <= '0;
            sym_idx   <= (sym_idx == 4'd13) ? 4'd0 : sym_idx + 4'd1;
          end else begin
            chunk_idx <= chunk_idx + 8'd1;
          end
        end else begin
          wr_re <= wr_re + 7'd1;
          if (re_in_prb == 4'd11) begin
            re_in_prb    <= '0;
            prb_in_chunk <= prb_in_chunk + 3'd1;
          end else begin
            re_in_prb <= re_in_prb + 4'd1;
          end
        end
      end
    end
  end

  // Output side: word generator feeding a one-deep AXI-style output register
  state_t       state, state_nxt;
  logic [6:0]   gaddr, re_lo, re_hi;
  logic [3:0]   off;
  logic         load;
  logic [63:0]  gen_data;
  logic [127:0] smp_lo, smp_hi;
  logic [2:0]   prb_lo, prb_hi;
  logic [13:0]  c_lo [4];
  logic [13:0]  c_hi [4];
  logic [15:0]  lane [4];
  logic         out_end;

  assign load      = (state != S_IDLE) && (!o_cpri_tx_vld || i_cpri_tx_ready);
  assign free_bank = load && (gaddr == LAST_ADDR);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (full[rbank]) state_nxt = S_HDR;
      S_HDR:  if (load && gaddr == 7'd6)  state_nxt = S_PAY;
      S_PAY:  if (load && gaddr == 7'd90) state_nxt = S_RSV;
      S_RSV:  if (load && gaddr == LAST_ADDR) state_nxt = full[~rbank] ? S_HDR : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= S_IDLE; gaddr <= '0; rbank <= 1'b0; re_lo <= '0; off <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        gaddr <= (gaddr == LAST_ADDR) ? 7'd0 : gaddr + 7'd1;
        if (gaddr == LAST_ADDR) rbank <= ~rbank;
        if (state == S_PAY) begin
          // 16 stream bits per word = one or two 14-bit codes consumed
          if (gaddr == 7'd90) begin
            re_lo <= '0; off <= '0;
          end else if (off < 4'd12) begin
            re_lo <= re_lo + 7'd1; off <= off + 4'd2;
          end else begin
            re_lo <= re_lo + 7'd2; off <= off - 4'd12;
          end
        end
      end
    end
  end

  always_comb begin
    re_hi  = re_lo + 7'd1;
    smp_lo = (re_lo < nre[rbank]) ? mem[rbank][re_lo] : '0;
    smp_hi = (re_hi < nre[rbank]) ? mem[rbank][re_hi] : '0;
    prb_lo = 3'(re_lo / 7'd12);
    prb_hi = 3'(re_hi / 7'd12);
    for (int a = 0; a < 4; a++) begin
      c_lo[a] = {compress(smp_lo[a*32+16 +: 16], agc[rbank][a*32 + 4*prb_lo +: 4]),
                 compress(smp_lo[a*32 +: 16],    agc[rbank][a*32 + 4*prb_lo +: 4])};
      c_hi[a] = {compress(smp_hi[a*32+16 +: 16], agc[rbank][a*32 + 4*prb_hi +: 4]),
                 compress(smp_hi[a*32 +: 16],    agc[rbank][a*32 + 4*prb_hi +: 4])};
      lane[a] = 16'({c_hi[a], c_lo[a]} >> off);
    end
  end

  always_comb begin
    gen_data = '0;
    case (state)
      S_HDR: begin
        if (gaddr == 7'd0)      gen_data = {40'h0, 4'h0, bsym[rbank], bchunk[rbank], 8'hA5};
        else if (gaddr == 7'd5) gen_data = agc[rbank][63:0];
        else if (gaddr == 7'd6) gen_data = agc[rbank][127:64];
      end
      S_PAY: for (int a = 0; a < 4; a++) gen_data[a*16 +: 16] = lane[a];
      default: gen_data = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_cpri_tx_vld <= 1'b0; o_cpri_tx_data <= '0; o_cpri_tx_addr <= '0;
      o_cpri_tx_last <= 1'b0; out_end <= 1'b0; o_sym_done <= 1'b0;
    end else begin
      o_sym_done <= o_cpri_tx_vld && i_cpri_tx_ready && o_cpri_tx_last && out_end;
      if (load) begin
        o_cpri_tx_vld  <= 1'b1;
        o_cpri_tx_data <= gen_data;
        o_cpri_tx_addr <= gaddr;
        o_cpri_tx_last <= (gaddr == LAST_ADDR);
        out_end        <= bend[rbank] && (gaddr == LAST_ADDR);
      end else if (i_cpri_tx_ready) begin
        o_cpri_tx_vld <= 1'b0;
      end
    end
  end

endmodule
